// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   uart_rx_state_t : receiver FSM state encoding
//   DATA_W          : data bits per frame
//   START_BIT/STOP_BIT : line levels of the framing bits
package uart_pkg;

   localparam int   DATA_W    = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 3-point majority vote around the middle of a bit.
//   clk, rst_n   : clock, async active-low reset
//   edge_cnt     : position within the current bit (0..OVERSAMPLE-1)
//   rx_s         : line sample
//   bit_val      : majority of samples at OS/2-1, OS/2, OS/2+1
//   sample_done  : strobe at edge OS/2+2, where bit_val is resolved
module uart_rx_sampler #(
   parameter int OVERSAMPLE = 8,
   parameter int EW         = $clog2(OVERSAMPLE)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [EW-1:0] edge_cnt,
   input  logic          rx_s,
   output logic          bit_val,
   output logic          sample_done
);

   localparam logic [EW-1:0] MID = EW'(OVERSAMPLE / 2);

   logic [2:0] samp_q, samp_d;

   always_comb begin
      samp_d = samp_q;
      if (edge_cnt == MID - EW'(1)) samp_d[0] = rx_s;
      if (edge_cnt == MID)          samp_d[1] = rx_s;
      if (edge_cnt == MID + EW'(1)) samp_d[2] = rx_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) samp_q <= 3'b111;
      else        samp_q <= samp_d;
   end

   assign bit_val     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                        (samp_q[1] & samp_q[2]);
   assign sample_done = (edge_cnt == MID + EW'(2));

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 8N1 with optional parity.
//   CLK, RST     : clock, async active-low reset
//   RX_IN        : serial line, idle high
//   PAR_EN/TYP   : parity present / odd(1) even(0), latched at start edge
//   P_DATA       : last good word
//   data_valid   : 1-cycle pulse when P_DATA updates
//   par_err      : 1-cycle pulse on parity mismatch
//   stp_err      : 1-cycle pulse when the stop bit samples 0
// Build option: UART_RX_SYNC_EN inserts a 2-flop input synchronizer.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX_IN,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   output logic [DATA_W-1:0] P_DATA,
   output logic              data_valid,
   output logic              par_err,
   output logic              stp_err
);

   localparam int EW = $clog2(OVERSAMPLE);

   if (!(OVERSAMPLE == 8 || OVERSAMPLE == 16 || OVERSAMPLE == 32)) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be 8, 16 or 32");
   end

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[0], RX_IN};
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) sync_q <= 2'b11;
      else      sync_q <= sync_d;
   end
   assign rx_s = sync_q[1];
`else
   assign rx_s = RX_IN;
`endif

   uart_rx_state_t    state_q, state_d;
   logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] p_data_q, p_data_d;
   logic par_en_q, par_en_d, par_typ_q, par_typ_d, par_bad_q, par_bad_d;
   logic rx_prev_q, rx_prev_d;
   logic data_valid_q, data_valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
   logic edge_wrap, bit_val, sample_done;

   uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .EW(EW)) u_sampler (
      .clk        (CLK),
      .rst_n      (RST),
      .edge_cnt   (edge_cnt_q),
      .rx_s       (rx_s),
      .bit_val    (bit_val),
      .sample_done(sample_done)
   );

   always_comb begin
      state_d      = state_q;
      edge_cnt_d   = edge_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      par_bad_d    = par_bad_q;
      rx_prev_d    = rx_s;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;
      edge_wrap    = (edge_cnt_q == EW'(OVERSAMPLE - 1));

      if (state_q != ST_IDLE)
         edge_cnt_d = edge_wrap ? '0 : edge_cnt_q + EW'(1);

      unique case (state_q)
         ST_IDLE: begin
            edge_cnt_d = '0;
            // Only a real high-to-low transition starts a frame; the
            // detect cycle itself counts as edge 0 of the start bit.
            if (rx_prev_q && rx_s == START_BIT) begin
               state_d    = ST_START;
               edge_cnt_d = EW'(1);
               par_en_d   = PAR_EN;
               par_typ_d  = PAR_TYP;
               par_bad_d  = 1'b0;
            end
         end
         ST_START: begin
            if (sample_done && bit_val != START_BIT) begin
               state_d    = ST_IDLE;
               edge_cnt_d = '0;
            end else if (edge_wrap) begin
               state_d   = ST_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (sample_done) shift_d = {bit_val, shift_q[DATA_W-1:1]};
            if (edge_wrap) begin
               if (bit_cnt_q == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
               else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         ST_PARITY: begin
            if (sample_done && (bit_val != (^shift_q ^ par_typ_q))) begin
               par_bad_d = 1'b1;
               par_err_d = 1'b1;
            end
            if (edge_wrap) state_d = ST_STOP;
         end
         ST_STOP: begin
            // Decide at mid-stop and drop back to IDLE so the next start
            // edge can follow as soon as the stop bit ends.
            if (sample_done) begin
               if (bit_val != STOP_BIT) begin
                  stp_err_d = 1'b1;
               end else if (!par_bad_q) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
               state_d    = ST_IDLE;
               edge_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            edge_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         p_data_q     <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad_q    <= 1'b0;
         rx_prev_q    <= 1'b1;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         par_bad_q    <= par_bad_d;
         rx_prev_q    <= rx_prev_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard of expected output pulses
// (kind, cycle, data); a negedge monitor pops and compares each pulse.
module tb_uart_rx;

   localparam int OS = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .P_DATA    (P_DATA),
      .data_valid(data_valid),
      .par_err   (par_err),
      .stp_err   (stp_err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // kind bits: {data_valid, par_err, stp_err}
   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if ({data_valid, par_err, stp_err} != 3'b000) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", int'({data_valid, par_err, stp_err}), 0);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", int'({data_valid, par_err, stp_err}), int'(e.kind));
            chk("pulse_cycle", cyc, e.cyc);
            if (e.kind[2]) chk("pulse_p_data", int'(P_DATA), int'(e.data));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      RX_IN = b;
      tick(OS);
   endtask

   // Drives one frame starting now (T0 = current cycle) and queues the
   // pulses it must produce. Parity inputs are flipped after the start
   // bit to show they are latched at the start edge.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic flip, input logic stop_v);
      int   t0;
      exp_t e;
      PAR_EN  = pen;
      PAR_TYP = ptyp;
      t0 = cyc;
      if (pen && flip) begin
         e.kind = 3'b010; e.data = 8'h00; e.cyc = t0 + 9*OS + OS/2 + 3;
         q.push_back(e);
      end
      if (!stop_v) begin
         e.kind = 3'b001; e.data = 8'h00; e.cyc = t0 + (9 + int'(pen))*OS + OS/2 + 3;
         q.push_back(e);
      end else if (!(pen && flip)) begin
         e.kind = 3'b100; e.data = d; e.cyc = t0 + (9 + int'(pen))*OS + OS/2 + 3;
         q.push_back(e);
      end
      drive_bit(1'b0);
      PAR_EN  = ~pen;
      PAR_TYP = ~ptyp;
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pen) drive_bit(^d ^ ptyp ^ flip);
      drive_bit(stop_v);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;
      // Reset state
      tick(3);
      chk("rst_p_data", int'(P_DATA), 0);
      chk("rst_data_valid", int'(data_valid), 0);
      chk("rst_par_err", int'(par_err), 0);
      chk("rst_stp_err", int'(stp_err), 0);
      RST = 1'b1;
      tick(20);

      // Plain frame, no parity: pulse at T0+79
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(5);
      // Even parity, correct parity bit: pulse at T0+87
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(5);
      // Wrong parity bit: par_err only, P_DATA held
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(5);
      chk("p_data_after_par_err", int'(P_DATA), 8'h3C);
      // Stop bit 0, then line held low: no further frame
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(40);
      chk("p_data_after_stp_err", int'(P_DATA), 8'h3C);
      RX_IN = 1'b1;
      tick(10);

      // Start glitch then a frame starting at glitch T0+8
      RX_IN = 1'b0;
      tick(2);
      RX_IN = 1'b1;
      tick(6);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(5);

      // Back-to-back frames, 10*OS apart
      send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(5);

      // Odd parity, correct bit
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(5);
      // Parity error and stop error in the same frame
      send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
      RX_IN = 1'b1;
      tick(10);
      chk("p_data_after_both_err", int'(P_DATA), 8'h07);

      // Reset during bit 4 of a frame
      PAR_EN = 1'b0;
      rd = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(rd[i]);
      RX_IN = rd[4];
      tick(3);
      RX_IN = 1'b1;
      RST = 1'b0;
      tick(1);
      chk("midrst_p_data", int'(P_DATA), 0);
      chk("midrst_data_valid", int'(data_valid), 0);
      chk("midrst_par_err", int'(par_err), 0);
      chk("midrst_stp_err", int'(stp_err), 0);
      tick(2);
      RST = 1'b1;
      tick(20);
      chk("post_rst_p_data", int'(P_DATA), 0);
      send_frame(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(10);
      chk("final_p_data", int'(P_DATA), 8'h42);
      chk("scoreboard_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
